// File: rtl/thread_pkg.sv
// Shared types for the two-thread switch controller.
// Thread ids, controller states and reset PC defaults.
package thread_pkg;

  localparam int unsigned NUM_THREADS = 2;

  localparam logic [31:0] DEFAULT_PC0 = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC1 = 32'h0000_1000;

  typedef logic [0:0] tid_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SWITCH   = 2'd1,
    COOLDOWN = 2'd2
  } ts_state_e;

endpackage

// File: rtl/thread_switch_controller_if.sv
// Thread-control bundle between the switch controller
// and the core (miss/fill inputs, switch/fetch outputs).
interface thread_switch_controller_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  import thread_pkg::*;

  logic                  mt_enable;
  logic                  dc_miss;
  logic [ADDR_WIDTH-1:0] mem_pc;
  logic                  mem_done;
  tid_t                  mem_done_tid;

  logic                  thread_switch;
  logic                  thread_switch_available;
  tid_t                  active_tid;
  logic                  load_pc_we;
  logic [ADDR_WIDTH-1:0] load_pc_new_pc;
  logic [31:0]           switch_count;

  modport master (
    input  mt_enable,
    input  dc_miss,
    input  mem_pc,
    input  mem_done,
    input  mem_done_tid,
    output thread_switch,
    output thread_switch_available,
    output active_tid,
    output load_pc_we,
    output load_pc_new_pc,
    output switch_count
  );

  modport slave (
    output mt_enable,
    output dc_miss,
    output mem_pc,
    output mem_done,
    output mem_done_tid,
    input  thread_switch,
    input  thread_switch_available,
    input  active_tid,
    input  load_pc_we,
    input  load_pc_new_pc,
    input  switch_count
  );

endinterface

// File: rtl/thread_context_file.sv
// Per-thread saved replay PC and blocked flag.
// One save port (switch), one clear port (fill done).
module thread_context_file
  import thread_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC0  = DEFAULT_PC0,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC1  = DEFAULT_PC1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  save_en,
  input  logic                  block_en,
  input  tid_t                  save_tid,
  input  logic [ADDR_WIDTH-1:0] save_pc,
  input  logic                  clr_en,
  input  tid_t                  clr_tid,
  input  tid_t                  rd_tid,
  output logic [ADDR_WIDTH-1:0] rd_pc,
  output logic                  rd_blocked
);

  logic [ADDR_WIDTH-1:0]  pc_q [NUM_THREADS];
  logic [ADDR_WIDTH-1:0]  pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0] blocked_q;
  logic [NUM_THREADS-1:0] blocked_d;

  // Fill clear first; a same-edge block of the
  // outgoing thread wins since it is a new miss.
  always_comb begin
    pc_d      = pc_q;
    blocked_d = blocked_q;
    if (clr_en) begin
      blocked_d[clr_tid] = 1'b0;
    end
    if (save_en) begin
      pc_d[save_tid] = save_pc;
      if (block_en) begin
        blocked_d[save_tid] = 1'b1;
      end
    end
  end

  // Context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q[0]   <= RESET_PC0;
      pc_q[1]   <= RESET_PC1;
      blocked_q <= '0;
    end else begin
      pc_q      <= pc_d;
      blocked_q <= blocked_d;
    end
  end

  assign rd_pc      = pc_q[rd_tid];
  assign rd_blocked = blocked_q[rd_tid];

endmodule

// File: rtl/thread_switch_controller.sv
// Two-thread switch controller: switches on D-cache miss.
// Optional timed switching under THREAD_QUANTUM_EN.
module thread_switch_controller
  import thread_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC0    = DEFAULT_PC0,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC1    = DEFAULT_PC1,
  parameter int unsigned           DRAIN_CYCLES = 2
`ifdef THREAD_QUANTUM_EN
  ,
  parameter int unsigned           QUANTUM      = 1024
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  thread_switch_controller_if.master  tif
);

  ts_state_e             state_q, state_d;
  tid_t                  active_q, active_d;
  logic                  ts_q, ts_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] npc_q, npc_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           swc_q, swc_d;

  tid_t                  oth;
  logic [ADDR_WIDTH-1:0] oth_pc;
  logic                  oth_blocked;
  logic                  avail;
  logic                  miss_go;
  logic                  q_go;
  logic                  go;

  assign oth     = ~active_q;
  assign avail   = tif.mt_enable & ~oth_blocked
                 & (state_q == RUN);
  assign miss_go = tif.dc_miss & avail;
  assign go      = miss_go | q_go;

`ifdef THREAD_QUANTUM_EN
  localparam int unsigned QW =
    (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QUANTUM - 1);

  logic [QW-1:0] qcnt_q, qcnt_d;
  logic          q_hit;

  assign q_hit = (qcnt_q == QLAST);
  assign q_go  = q_hit & avail & ~miss_go;

  // RUN-cycle counter since the last switch.
  always_comb begin
    qcnt_d = qcnt_q;
    if (state_q != RUN || go) begin
      qcnt_d = '0;
    end else if (!q_hit) begin
      qcnt_d = qcnt_q + 1'b1;
    end
  end

  // Quantum counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt_q <= '0;
    end else begin
      qcnt_q <= qcnt_d;
    end
  end
`else
  assign q_go = 1'b0;
`endif

  thread_context_file #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC0  (RESET_PC0),
    .RESET_PC1  (RESET_PC1)
  ) u_ctx (
    .clk        (clk),
    .rst_n      (rst_n),
    .save_en    (go),
    .block_en   (miss_go),
    .save_tid   (active_q),
    .save_pc    (tif.mem_pc),
    .clr_en     (tif.mem_done),
    .clr_tid    (tif.mem_done_tid),
    .rd_tid     (oth),
    .rd_pc      (oth_pc),
    .rd_blocked (oth_blocked)
  );

  // Next state and registered switch outputs.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    ts_d     = 1'b0;
    we_d     = 1'b0;
    npc_d    = npc_q;
    cnt_d    = cnt_q;
    swc_d    = swc_q;
    unique case (state_q)
      RUN: begin
        if (go) begin
          state_d  = SWITCH;
          active_d = oth;
          ts_d     = 1'b1;
          we_d     = 1'b1;
          npc_d    = oth_pc;
        end
      end
      SWITCH: begin
        state_d = COOLDOWN;
        cnt_d   = 4'(DRAIN_CYCLES);
        if (swc_q != 32'hFFFF_FFFF) begin
          swc_d = swc_q + 32'd1;
        end
      end
      COOLDOWN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      active_q <= '0;
      ts_q     <= 1'b0;
      we_q     <= 1'b0;
      npc_q    <= '0;
      cnt_q    <= '0;
      swc_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      ts_q     <= ts_d;
      we_q     <= we_d;
      npc_q    <= npc_d;
      cnt_q    <= cnt_d;
      swc_q    <= swc_d;
    end
  end

  assign tif.thread_switch           = ts_q;
  assign tif.load_pc_we              = we_q;
  assign tif.load_pc_new_pc          = npc_q;
  assign tif.active_tid              = active_q;
  assign tif.switch_count            = swc_q;
  assign tif.thread_switch_available = avail;

endmodule

// File: tb/tb_thread_switch_controller.sv
// Bench for thread_switch_controller: directed scenarios
// plus random traffic against a timeline model.
module tb_thread_switch_controller;

  localparam int DRAIN = 2;
`ifdef THREAD_QUANTUM_EN
  localparam int Q = 16;
`endif

  logic clk;
  logic rst_n;

  thread_switch_controller_if #(.ADDR_WIDTH(32)) tif ();

  thread_switch_controller #(
    .ADDR_WIDTH   (32),
    .RESET_PC0    (32'h0000_0000),
    .RESET_PC1    (32'h0000_1000),
    .DRAIN_CYCLES (DRAIN)
`ifdef THREAD_QUANTUM_EN
    ,
    .QUANTUM      (Q)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tif   (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: a timeline of switch pulses rather than states.
  int          cyc;
  int          last_pulse;
  int          run_start;
  bit          m_act;
  logic [31:0] m_pc [2];
  bit          m_blk [2];
  logic [31:0] m_lpc;
  logic [31:0] m_cnt;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc        = 0;
    last_pulse = -100;
    run_start  = 0;
    m_act      = 1'b0;
    m_pc[0]    = 32'h0000_0000;
    m_pc[1]    = 32'h0000_1000;
    m_blk[0]   = 1'b0;
    m_blk[1]   = 1'b0;
    m_lpc      = '0;
    m_cnt      = '0;
  endtask

  // Called just after a posedge; reset acts at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ts",  tif.thread_switch,  0);
    chk("rst_we",  tif.load_pc_we,     0);
    chk("rst_act", tif.active_tid,     0);
    chk("rst_lpc", tif.load_pc_new_pc, 0);
    chk("rst_cnt", tif.switch_count,   0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic tick();
    bit oth, exp_ts, exp_av, miss, quant, take;
    @(negedge clk);
    oth    = ~m_act;
    exp_ts = (cyc == last_pulse);
    exp_av = tif.mt_enable && !m_blk[oth]
             && (cyc >= run_start);
    chk("ts",    tif.thread_switch, exp_ts);
    chk("we",    tif.load_pc_we, exp_ts);
    chk("act",   tif.active_tid, m_act);
    chk("lpc",   tif.load_pc_new_pc, m_lpc);
    chk("count", tif.switch_count, m_cnt);
    chk("avail", tif.thread_switch_available, exp_av);
    miss  = tif.dc_miss && exp_av;
    quant = 1'b0;
`ifdef THREAD_QUANTUM_EN
    quant = !miss && exp_av && (cyc - run_start >= Q - 1);
`endif
    take = miss || quant;
    if (exp_ts && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    if (tif.mem_done) m_blk[tif.mem_done_tid] = 1'b0;
    if (take) begin
      m_lpc       = m_pc[oth];
      m_pc[m_act] = tif.mem_pc;
      if (miss) m_blk[m_act] = 1'b1;
      m_act      = oth;
      last_pulse = cyc + 1;
      run_start  = cyc + 2 + DRAIN;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_inputs();
    tif.mt_enable    = 1'b1;
    tif.dc_miss      = 1'b0;
    tif.mem_pc       = '0;
    tif.mem_done     = 1'b0;
    tif.mem_done_tid = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;

    // Miss on thread 0, then thread 1 blocked on 0.
    do_reset();
    ticks(5);
    tif.dc_miss = 1'b1;
    tif.mem_pc  = 32'h40;
    tick();
    tif.dc_miss = 1'b0;
    ticks(4);
    tif.dc_miss = 1'b1;
    tif.mem_pc  = 32'h1010;
    ticks(6);
    tif.mem_done     = 1'b1;
    tif.mem_done_tid = 1'b0;
    tick();
    tif.mem_done = 1'b0;
    ticks(3);
    tif.dc_miss = 1'b0;
    ticks(2);
    tif.mem_done     = 1'b1;
    tif.mem_done_tid = 1'b1;
    tick();
    tif.mem_done = 1'b0;
    ticks(3);

    // Single-thread mode ignores misses.
    do_reset();
    tif.mt_enable = 1'b0;
    tif.dc_miss   = 1'b1;
    tif.mem_pc    = 32'h80;
    ticks(20);

    // Miss held high: cooldown spacing, then fill.
    do_reset();
    tif.mt_enable = 1'b1;
    tif.dc_miss   = 1'b1;
    tif.mem_pc    = 32'h200;
    ticks(15);
    tif.mem_done     = 1'b1;
    tif.mem_done_tid = 1'b0;
    tick();
    tif.mem_done = 1'b0;
    ticks(10);

    // Reset during the switch cycle.
    idle_inputs();
    do_reset();
    ticks(2);
    tif.dc_miss = 1'b1;
    tif.mem_pc  = 32'h300;
    tick();
    do_reset();
    ticks(4);

    // No misses: only timed switches, if enabled.
    idle_inputs();
    do_reset();
    for (int i = 0; i < 80; i++) begin
      tif.mem_pc = 32'h500 + 32'(i * 4);
      tick();
    end

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      tif.mt_enable    = ($urandom_range(0, 15) != 0);
      tif.dc_miss      = ($urandom_range(0, 2) == 0);
      tif.mem_pc       = $urandom() & 32'hFFFF_FFFC;
      tif.mem_done     = ($urandom_range(0, 5) == 0);
      tif.mem_done_tid = 1'($urandom_range(0, 1));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
